// File: rtl/subleq_mem_arbiter_pkg.sv
// Shared encodings for the subleq memory-port arbiter: FSM states and master ids.
package subleq_mem_arbiter_pkg;

  localparam int unsigned WordSize = 16;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbBusy = 2'd1,
    ArbDone = 2'd2,
    ArbHold = 2'd3
  } arb_state_e;

  localparam logic ArbMCpu = 1'b0;
  localparam logic ArbMLdr = 1'b1;

endpackage

// File: rtl/subleq_arb_mux.sv
// Combinational master select for the arbiter: forwards the granted master's strobes, address and
// write data to memory and steers mem_ack back to that master only.
module subleq_arb_mux
  import subleq_mem_arbiter_pkg::*;
#(
  parameter int unsigned W = WordSize
) (
  input  logic         g_i,
  input  logic         active_i,
  input  logic         cpu_load_i,
  input  logic         cpu_store_i,
  input  logic [W-1:0] cpu_addr_i,
  input  logic [W-1:0] cpu_wdata_i,
  input  logic         ldr_load_i,
  input  logic         ldr_store_i,
  input  logic [W-1:0] ldr_addr_i,
  input  logic [W-1:0] ldr_wdata_i,
  input  logic         mem_ack_i,
  output logic         mem_load_o,
  output logic         mem_store_o,
  output logic [W-1:0] mem_addr_o,
  output logic [W-1:0] mem_wdata_o,
  output logic         cpu_ack_o,
  output logic         ldr_ack_o
);

  always_comb begin
    mem_load_o  = 1'b0;
    mem_store_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    cpu_ack_o   = 1'b0;
    ldr_ack_o   = 1'b0;
    if (active_i) begin
      if (g_i == ArbMLdr) begin
        mem_load_o  = ldr_load_i;
        mem_store_o = ldr_store_i;
        mem_addr_o  = ldr_addr_i;
        mem_wdata_o = ldr_wdata_i;
        ldr_ack_o   = mem_ack_i;
      end else begin
        mem_load_o  = cpu_load_i;
        mem_store_o = cpu_store_i;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        cpu_ack_o   = mem_ack_i;
      end
    end
  end

endmodule

// File: rtl/subleq_mem_arbiter.sv
// Two-master (CPU / loader) arbiter for the single subleq memory port with loader bus locking.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed loader-first priority.
module subleq_mem_arbiter
  import subleq_mem_arbiter_pkg::*;
#(
  parameter int unsigned W            = WordSize,
  parameter int unsigned LOCK_TIMEOUT = 0,
  parameter int unsigned TW           = 16
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         cpu_req,
  output logic         cpu_ack,
  input  logic         cpu_load,
  input  logic         cpu_store,
  input  logic [W-1:0] cpu_addr,
  input  logic [W-1:0] cpu_wdata,
  output logic [W-1:0] cpu_rdata,
  input  logic         ldr_req,
  output logic         ldr_ack,
  input  logic         ldr_load,
  input  logic         ldr_store,
  input  logic [W-1:0] ldr_addr,
  input  logic [W-1:0] ldr_wdata,
  output logic [W-1:0] ldr_rdata,
  input  logic         ldr_lock,
  output logic         mem_req,
  input  logic         mem_ack,
  output logic         mem_load,
  output logic         mem_store,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  output logic         gnt_cpu,
  output logic         gnt_ldr
);

  arb_state_e    state_q, state_d;
  logic          g_q, g_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0]   cnt_inc;
  logic          req_g;
  logic          active;
  logic          timeout;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;
`endif

  assign req_g   = (g_q == ArbMLdr) ? ldr_req : cpu_req;
  assign active  = (state_q == ArbBusy) || (state_q == ArbDone);
  assign cnt_inc = 32'(cnt_q) + 32'd1;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    mem_req = 1'b0;
    timeout = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      ArbIdle: begin
        if (cpu_req || ldr_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          g_d = (cpu_req && ldr_req) ? ~rr_q : ldr_req;
`else
          g_d = ldr_req ? ArbMLdr : ArbMCpu;
`endif
          state_d = ArbBusy;
        end
      end
      ArbBusy: begin
        // A master dropping req before ack is forwarded as-is; only mem_ack advances the FSM.
        mem_req = req_g;
        if (mem_ack) state_d = ArbDone;
      end
      ArbDone: begin
        mem_req = req_g;
        if (!req_g && !mem_ack) begin
          if ((g_q == ArbMLdr) && ldr_lock) begin
            state_d = ArbHold;
            cnt_d   = '0;
          end else begin
            state_d = ArbIdle;
          end
        end
      end
      ArbHold: begin
        if (cpu_req && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        timeout = (LOCK_TIMEOUT != 0) && cpu_req && (cnt_inc == LOCK_TIMEOUT);
        if (ldr_req) begin
          state_d = ArbBusy;
          g_d     = ArbMLdr;
        end else if (!ldr_lock || timeout) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
`ifdef ARB_ROUND_ROBIN_EN
    if ((state_d == ArbBusy) && (state_q != ArbBusy)) rr_d = g_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= ArbIdle;
      g_q     <= ArbMCpu;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (areset) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`endif

  subleq_arb_mux #(
    .W(W)
  ) u_mux (
    .g_i        (g_q),
    .active_i   (active),
    .cpu_load_i (cpu_load),
    .cpu_store_i(cpu_store),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .ldr_load_i (ldr_load),
    .ldr_store_i(ldr_store),
    .ldr_addr_i (ldr_addr),
    .ldr_wdata_i(ldr_wdata),
    .mem_ack_i  (mem_ack),
    .mem_load_o (mem_load),
    .mem_store_o(mem_store),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .cpu_ack_o  (cpu_ack),
    .ldr_ack_o  (ldr_ack)
  );

  assign cpu_rdata = mem_rdata;
  assign ldr_rdata = mem_rdata;
  assign gnt_cpu   = (state_q != ArbIdle) && (g_q == ArbMCpu);
  assign gnt_ldr   = (state_q != ArbIdle) && (g_q == ArbMLdr);

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// Directed bench for subleq_mem_arbiter with a 2-cycle-latency memory model; honours
// ARB_ROUND_ROBIN_EN for the back-to-back tie scenario.
module tb_subleq_mem_arbiter;

  localparam int unsigned W      = 16;
  localparam int          Budget = 80;

  logic         clk = 1'b0;
  logic         areset;
  logic         cpu_req, cpu_ack, cpu_load, cpu_store;
  logic [W-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic         ldr_req, ldr_ack, ldr_load, ldr_store, ldr_lock;
  logic [W-1:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic         mem_req, mem_ack, mem_load, mem_store;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         gnt_cpu, gnt_ldr;

  always #5 clk = ~clk;

  subleq_mem_arbiter #(
    .W           (W),
    .LOCK_TIMEOUT(5),
    .TW          (16)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .cpu_req  (cpu_req),
    .cpu_ack  (cpu_ack),
    .cpu_load (cpu_load),
    .cpu_store(cpu_store),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .ldr_req  (ldr_req),
    .ldr_ack  (ldr_ack),
    .ldr_load (ldr_load),
    .ldr_store(ldr_store),
    .ldr_addr (ldr_addr),
    .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata),
    .ldr_lock (ldr_lock),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_load (mem_load),
    .mem_store(mem_store),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .gnt_cpu  (gnt_cpu),
    .gnt_ldr  (gnt_ldr)
  );

  // Memory model: ack two cycles after seeing req, drop ack once req drops.
  logic [W-1:0] mem_model [256];
  logic         dly;
  always @(posedge clk) begin
    if (areset) begin
      mem_ack   <= 1'b0;
      dly       <= 1'b0;
      mem_rdata <= '0;
      for (int i = 0; i < 256; i++) mem_model[i] <= 16'h5A00 | 16'(i);
    end else if (mem_req && !mem_ack) begin
      if (dly) begin
        mem_ack <= 1'b1;
        dly     <= 1'b0;
        if (mem_store) mem_model[mem_addr[7:0]] <= mem_wdata;
        if (mem_load)  mem_rdata <= mem_model[mem_addr[7:0]];
      end else begin
        dly <= 1'b1;
      end
    end else if (!mem_req && mem_ack) begin
      mem_ack <= 1'b0;
    end
  end

  // Grant monitor: logs rising grants (1 = loader, 0 = CPU) and edge cycles.
  int   cyc = 0;
  int   gnt_log[$];
  logic cpu_prev = 1'b0;
  logic ldr_prev = 1'b0;
  int   ldr_fall_cyc = 0;
  int   cpu_rise_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (gnt_ldr && !ldr_prev) gnt_log.push_back(1);
    if (gnt_cpu && !cpu_prev) begin
      gnt_log.push_back(0);
      cpu_rise_cyc <= cyc;
    end
    if (!gnt_ldr && ldr_prev) ldr_fall_cyc <= cyc;
    ldr_prev <= gnt_ldr;
    cpu_prev <= gnt_cpu;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  int ldr_done_cyc = 0;
  int lock_drop_cyc = 0;

  task automatic cpu_xact(input logic st, input logic [W-1:0] a, input logic [W-1:0] d,
                          output logic [W-1:0] rd);
    int n;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_store = st; cpu_load = !st; cpu_addr = a; cpu_wdata = d;
    n = 0;
    @(negedge clk);
    while (!cpu_ack && n < Budget) begin @(negedge clk); n++; end
    check("cpu_ack_up", cpu_ack, 1);
    rd = cpu_rdata;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_store = 1'b0; cpu_load = 1'b0;
    n = 0;
    @(negedge clk);
    while (cpu_ack && n < Budget) begin @(negedge clk); n++; end
    check("cpu_ack_down", cpu_ack, 0);
  endtask

  task automatic ldr_xact(input logic st, input logic [W-1:0] a, input logic [W-1:0] d,
                          output logic [W-1:0] rd);
    int n;
    @(posedge clk); #1;
    ldr_req = 1'b1; ldr_store = st; ldr_load = !st; ldr_addr = a; ldr_wdata = d;
    n = 0;
    @(negedge clk);
    while (!ldr_ack && n < Budget) begin @(negedge clk); n++; end
    check("ldr_ack_up", ldr_ack, 1);
    rd = ldr_rdata;
    @(posedge clk); #1;
    ldr_req = 1'b0; ldr_store = 1'b0; ldr_load = 1'b0;
    n = 0;
    @(negedge clk);
    while (ldr_ack && n < Budget) begin @(negedge clk); n++; end
    check("ldr_ack_down", ldr_ack, 0);
    ldr_done_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((gnt_cpu || gnt_ldr) && n < Budget) begin @(negedge clk); n++; end
    check(tag, {30'd0, gnt_cpu, gnt_ldr}, 0);
  endtask

  int           n;
  int           base;
  int           exp3[4];
  logic [W-1:0] rd_c, rd_l;

  initial begin
    areset = 1'b1;
    cpu_req = 1'b0; cpu_load = 1'b0; cpu_store = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_load = 1'b0; ldr_store = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    ldr_lock = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_acks", {30'd0, cpu_ack, ldr_ack}, 0);
    check("rst_gnts", {30'd0, gnt_cpu, gnt_ldr}, 0);
    check("rst_strobes", {30'd0, mem_load, mem_store}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    @(posedge clk); #1 areset = 1'b0;

    // Single CPU read with exact cycle checks.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_load = 1'b1; cpu_addr = 16'h0010;
    @(negedge clk);
    check("t1_req_same_cycle", mem_req, 0);
    @(negedge clk);
    check("t1_mem_req", mem_req, 1);
    check("t1_gnt_cpu", gnt_cpu, 1);
    check("t1_gnt_ldr", gnt_ldr, 0);
    check("t1_mem_addr", mem_addr, 16'h0010);
    check("t1_mem_load", mem_load, 1);
    check("t1_cpu_ack_early", cpu_ack, 0);
    n = 0;
    while (!cpu_ack && n < 10) begin @(negedge clk); n++; end
    check("t1_ack_latency", n, 2);
    check("t1_cpu_rdata", cpu_rdata, 16'h5A10);
    check("t1_ldr_rdata", ldr_rdata, 16'h5A10);
    check("t1_ldr_ack", ldr_ack, 0);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_load = 1'b0;
    n = 0;
    @(negedge clk);
    while (cpu_ack && n < 10) begin @(negedge clk); n++; end
    check("t1_ack_down", cpu_ack, 0);
    wait_idle("t1_idle");
    check("t1_idle_addr", mem_addr, 0);

    // Simultaneous requests: loader first, CPU granted the cycle after IDLE.
    base = gnt_log.size();
    fork
      cpu_xact(1'b0, 16'h0020, 16'h0000, rd_c);
      ldr_xact(1'b0, 16'h0021, 16'h0000, rd_l);
    join
    wait_idle("t2_idle");
    check("t2_log_size", gnt_log.size() - base, 2);
    check("t2_first_ldr", gnt_log[base], 1);
    check("t2_second_cpu", gnt_log[base+1], 0);
    check("t2_cpu_after_idle", cpu_rise_cyc - ldr_fall_cyc, 1);
    check("t2_cpu_rdata", rd_c, 16'h5A20);
    check("t2_ldr_rdata", rd_l, 16'h5A21);

    // Back-to-back ties, two transactions per master.
`ifdef ARB_ROUND_ROBIN_EN
    exp3 = '{1, 0, 1, 0};
`else
    exp3 = '{1, 1, 0, 0};
`endif
    base = gnt_log.size();
    fork
      begin
        cpu_xact(1'b0, 16'h0001, 16'h0000, rd_c);
        cpu_xact(1'b0, 16'h0002, 16'h0000, rd_c);
      end
      begin
        ldr_xact(1'b0, 16'h0003, 16'h0000, rd_l);
        ldr_xact(1'b0, 16'h0004, 16'h0000, rd_l);
      end
    join
    wait_idle("t3_idle");
    check("t3_log_size", gnt_log.size() - base, 4);
    for (int k = 0; k < 4; k++) check($sformatf("t3_gnt%0d", k), gnt_log[base+k], exp3[k]);

    // Locked loader burst while the CPU waits.
    base = gnt_log.size();
    ldr_lock = 1'b1;
    fork
      cpu_xact(1'b0, 16'h0030, 16'h0000, rd_c);
      begin
        for (int k = 0; k < 3; k++) ldr_xact(1'b1, 16'(k), 16'hC0DE + 16'(k), rd_l);
        @(posedge clk); #1;
        ldr_lock = 1'b0;
        lock_drop_cyc = cyc;
      end
    join
    wait_idle("t4_idle");
    check("t4_log_size", gnt_log.size() - base, 2);
    check("t4_first_ldr", gnt_log[base], 1);
    check("t4_then_cpu", gnt_log[base+1], 0);
    check("t4_cpu_after_unlock", cpu_rise_cyc - lock_drop_cyc, 2);
    check("t4_cpu_rdata", rd_c, 16'h5A30);
    check("t4_mem0", mem_model[0], 16'hC0DE);
    check("t4_mem1", mem_model[1], 16'hC0DF);
    check("t4_mem2", mem_model[2], 16'hC0E0);

    // Lock timeout: one DONE cycle then five HOLD cycles before IDLE.
    ldr_lock = 1'b1;
    fork
      cpu_xact(1'b0, 16'h0031, 16'h0000, rd_c);
      ldr_xact(1'b1, 16'h0003, 16'hABCD, rd_l);
    join
    ldr_lock = 1'b0;
    wait_idle("t5_idle");
    check("t5_hold_len", ldr_fall_cyc - ldr_done_cyc, 6);
    check("t5_cpu_next", cpu_rise_cyc - ldr_fall_cyc, 1);
    check("t5_cpu_rdata", rd_c, 16'h5A31);
    check("t5_mem3", mem_model[3], 16'hABCD);

    // Reset while BUSY.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_store = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    check("t6_busy_pre", gnt_cpu, 1);
    @(posedge clk); #1 areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_mem_req", mem_req, 0);
    check("t6_acks", {30'd0, cpu_ack, ldr_ack}, 0);
    check("t6_gnts", {30'd0, gnt_cpu, gnt_ldr}, 0);
    check("t6_store", mem_store, 0);
    check("t6_addr", mem_addr, 0);
    @(posedge clk); #1;
    areset = 1'b0; cpu_req = 1'b0; cpu_store = 1'b0;
    ldr_xact(1'b0, 16'h0005, 16'h0000, rd_l);
    check("t6_recover_rdata", rd_l, 16'h5A05);
    wait_idle("t6_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
